// File: rtl/tlc_pkg.sv
// Shared constants for the traffic-light controller slice: lamp status
// encoding and default blink half-periods.
package tlc_pkg;

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_ON    = 2'b01;
  localparam logic [1:0] ST_BLINK = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam int unsigned HALF_PERIOD_SIM   = 500;
  localparam int unsigned HALF_PERIOD_BOARD = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (lamp feedback,
// push buttons). Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage shift;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/blink_monitor.sv
// Lamp blink monitor: measures each high/low level length of the lamp signal
// and classifies it as steady OFF, steady ON, BLINK, or RATE_FAULT.
module blink_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_SIM,
  parameter int unsigned TOL         = 50,
  parameter int unsigned STUCK_TICKS = 1500,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid
);

  localparam logic [CNT_W-1:0] HP_C    = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(STUCK_TICKS);

  logic             sync;
  logic             level_prev;
  logic [CNT_W-1:0] run_cnt;
  logic             first_seg;
  logic [1:0]       good_cnt;

  logic             lvl_edge;
  logic             stuck_hit;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] dev;
  logic             in_tol;
  logic [1:0]       good_inc;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .q     (sync)
  );

  // NOTE: every output of this block is assigned a default first so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    lvl_edge  = 1'b0;
    stuck_hit = 1'b0;
    meas      = '0;
    dev       = '0;
    in_tol    = 1'b0;
    good_inc  = 2'd0;

    lvl_edge  = (sync != level_prev);
    // An edge in the same cycle as the threshold wins over stuck detection.
    stuck_hit = !lvl_edge && (run_cnt == STUCK_C - CNT_W'(1));
    meas      = run_cnt + CNT_W'(1);
    dev       = (meas >= HP_C) ? (meas - HP_C) : (HP_C - meas);
    in_tol    = (dev <= TOL_C);
    good_inc  = (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_prev  <= 1'b0;
      run_cnt     <= '0;
      first_seg   <= 1'b1;
      good_cnt    <= 2'd0;
      status      <= ST_OFF;
      half_period <= '0;
      meas_valid  <= 1'b0;
    end else begin
      level_prev <= sync;
      meas_valid <= 1'b0;

      if (lvl_edge) begin
        run_cnt <= '0;
        if (first_seg) begin
          // Partial segment after reset or stuck: length is meaningless.
          first_seg <= 1'b0;
        end else begin
          half_period <= meas;
          meas_valid  <= 1'b1;
          if (!in_tol) begin
            status   <= ST_FAULT;
            good_cnt <= 2'd0;
          end else begin
            good_cnt <= good_inc;
            if (good_inc == 2'd2) status <= ST_BLINK;
          end
        end
      end else begin
        if (run_cnt < STUCK_C) run_cnt <= run_cnt + CNT_W'(1);
        if (stuck_hit) begin
          status    <= sync ? ST_ON : ST_OFF;
          first_seg <= 1'b1;
          good_cnt  <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Self-checking bench for blink_monitor: directed scenarios plus random level
// lengths, compared every cycle against a segment-timestamp reference model.
module tb_blink_monitor;

  localparam int HP    = 500;
  localparam int TOL   = 50;
  localparam int STUCK = 1500;
  localparam int CNT_W = 26;

  localparam logic [1:0] E_OFF   = 2'b00;
  localparam logic [1:0] E_ON    = 2'b01;
  localparam logic [1:0] E_BLINK = 2'b10;
  localparam logic [1:0] E_FAULT = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [1:0]       status;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;

  blink_monitor #(
    .HALF_PERIOD (HP),
    .TOL         (TOL),
    .STUCK_TICKS (STUCK),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .status      (status),
    .half_period (half_period),
    .meas_valid  (meas_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state. The synchronized level seen by the monitor is the
  // input delayed by two edges; segments are tracked by start timestamps.
  int         k;          // edges since reset release
  int         seg_start;  // edge index at which the current synced level began
  bit         d1, yk, ykm1;
  bit         m_first;
  int         m_run_good; // consecutive in-tolerance measurements
  logic [1:0] m_status;
  int         m_hp;
  bit         m_mv;
  bit         cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  function automatic void model_edge(input bit x, input bit r);
    if (r) begin
      k = 0; seg_start = -1; d1 = 0; yk = 0; ykm1 = 0;
      m_first = 1; m_run_good = 0; m_status = E_OFF; m_hp = 0; m_mv = 0;
      return;
    end
    k++;
    m_mv = 0;
    if (yk != ykm1) begin
      if (m_first) m_first = 0;
      else begin
        m_hp = (k - 1) - seg_start;
        m_mv = 1;
        if (m_hp >= HP - TOL && m_hp <= HP + TOL) begin
          m_run_good++;
          if (m_run_good >= 2) m_status = E_BLINK;
        end else begin
          m_status   = E_FAULT;
          m_run_good = 0;
        end
      end
      seg_start = k - 1;
    end else if (k == seg_start + STUCK + 1) begin
      m_status   = yk ? E_ON : E_OFF;
      m_first    = 1;
      m_run_good = 0;
    end
    ykm1 = yk;
    yk   = d1;
    d1   = x;
  endfunction

  task automatic step(input bit x, input bit r);
    @(negedge clk);
    sig_in = x;
    reset  = r;
    @(posedge clk);
    model_edge(x, r);
    #1;
    check("status", 32'(status), 32'(m_status));
    check("half_period", 32'(half_period), 32'(m_hp));
    check("meas_valid", 32'(meas_valid), 32'(m_mv));
  endtask

  task automatic level(input bit x, input int n);
    cur = x;
    repeat (n) step(x, 1'b0);
  endtask

  task automatic seg(input int n);
    level(~cur, n);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(cur, 1'b1);
  endtask

  initial begin
    sig_in = 1'b0;
    reset  = 1'b1;
    cur    = 1'b0;
    do_reset(3);
    check("reset_status", 32'(status), 32'(E_OFF));
    check("reset_half_period", 32'(half_period), 32'd0);

    // Steady high from reset must read ON after saturation.
    level(1'b1, 1510);
    check("stuck_on", 32'(status), 32'(E_ON));

    // Nominal blink from low.
    cur = 1'b0;
    do_reset(2);
    level(1'b0, 500);
    repeat (4) seg(500);
    check("blink_nominal", 32'(status), 32'(E_BLINK));

    // One long half faults, two good halves recover.
    seg(600); seg(500);
    check("fault_600", 32'(status), 32'(E_FAULT));
    seg(500); seg(500);
    check("recover", 32'(status), 32'(E_BLINK));

    // Inclusive tolerance bounds.
    seg(450); seg(550); seg(500);
    check("tol_450_550", 32'(status), 32'(E_BLINK));
    seg(449); seg(500);
    check("tol_449", 32'(status), 32'(E_FAULT));
    repeat (3) seg(500);
    seg(551); seg(500);
    check("tol_551", 32'(status), 32'(E_FAULT));
    repeat (3) seg(500);
    check("blink_again", 32'(status), 32'(E_BLINK));

    // Stuck low, then resume.
    if (cur) seg(500);
    level(1'b0, 1600);
    check("stuck_off", 32'(status), 32'(E_OFF));
    repeat (4) seg(500);
    check("blink_after_stuck", 32'(status), 32'(E_BLINK));

    // Reset mid-level while blinking.
    level(cur, 200);
    do_reset(1);
    check("midrst_status", 32'(status), 32'(E_OFF));
    check("midrst_half_period", 32'(half_period), 32'd0);
    check("midrst_meas_valid", 32'(meas_valid), 32'd0);
    repeat (4) seg(500);

    // Random level lengths around nominal, tolerance edges and stuck edge.
    repeat (70) begin
      int r;
      int len;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset(int'($urandom_range(1, 2)));
        len = 500;
      end else if (r < 63) len = int'($urandom_range(440, 560));
      else if (r < 73) begin
        case ($urandom_range(0, 3))
          0: len = 449;
          1: len = 450;
          2: len = 550;
          default: len = 551;
        endcase
      end else if (r < 83) len = int'($urandom_range(1, 1000));
      else if (r < 93) len = int'($urandom_range(1495, 1510));
      else len = 500;
      seg(len);
    end
    level(cur, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
